// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - writeback requesters, decode claim and register-file write port bundle
interface regfile_wb_sched_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              i_a_valid;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_data;
    logic              o_a_ready;

    logic              i_b_valid;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_data;
    logic              o_b_ready;

    logic              i_claim_valid;
    logic [ADDR_W-1:0] i_claim_addr;
    logic [31:0]       o_busy;

    logic              o_rf_we;
    logic [ADDR_W-1:0] o_rf_wa;
    logic [DATA_W-1:0] o_rf_wd;

    modport master (
        output i_a_valid, i_a_addr, i_a_data,
        output i_b_valid, i_b_addr, i_b_data,
        output i_claim_valid, i_claim_addr,
        input  o_a_ready, o_b_ready, o_busy,
        input  o_rf_we, o_rf_wa, o_rf_wd
    );

    modport slave (
        input  i_a_valid, i_a_addr, i_a_data,
        input  i_b_valid, i_b_addr, i_b_data,
        input  i_claim_valid, i_claim_addr,
        output o_a_ready, o_b_ready, o_busy,
        output o_rf_we, o_rf_wa, o_rf_wd
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - round-robin writeback port scheduler with pending-write scoreboard (REGFILE_WB_SCOREBOARD_EN)
module regfile_wb_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    regfile_wb_sched_if.slave   bus
);
    logic              last_b;
    logic              a_ready;
    logic              b_ready;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_wa_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              accept;

    // Contention goes to whichever requester did not win the previous accept.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rstn) begin
            a_ready = bus.i_a_valid && (!bus.i_b_valid || last_b);
            b_ready = bus.i_b_valid && (!bus.i_a_valid || !last_b);
        end
    end

    assign accept   = a_ready || b_ready;
    assign acc_addr = a_ready ? bus.i_a_addr : bus.i_b_addr;
    assign acc_data = a_ready ? bus.i_a_data : bus.i_b_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_b  <= 1'b1;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            if (accept) begin
                last_b  <= b_ready;
                rf_wa_q <= acc_addr;
                rf_wd_q <= acc_data;
                rf_we_q <= (acc_addr != '0);
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.o_a_ready = a_ready;
    assign bus.o_b_ready = b_ready;
    assign bus.o_rf_we   = rf_we_q;
    assign bus.o_rf_wa   = rf_wa_q;
    assign bus.o_rf_wd   = rf_wd_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear first so a same-cycle claim of the committing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q)
            busy_d[rf_wa_q] = 1'b0;
        if (bus.i_claim_valid && (bus.i_claim_addr != '0))
            busy_d[bus.i_claim_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign bus.o_busy = busy_q;
`else
    logic unused_claim;
    assign unused_claim = ^{bus.i_claim_valid, bus.i_claim_addr};
    assign bus.o_busy   = '0;
`endif
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler for the 32×32 register file in the multi-cycle CPU. Arbitrates two writeback requesters (A: ALU/execute, B: memory/mul-div) onto the single register-file write port with round-robin fairness and registers the winning write. Maintains a per-register pending (busy) scoreboard so decode can stall on registers whose producer has not yet written back.

## Interface
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- i_a_valid  in  1  requester A has a write
- i_a_addr  in  ADDR_W  A destination register
- i_a_data  in  DATA_W  A write data
- o_a_ready  out  1  A granted this cycle
- i_b_valid / i_b_addr / i_b_data  in  1/ADDR_W/DATA_W  requester B, same meaning
- o_b_ready  out  1  B granted this cycle
- i_claim_valid  in  1  decode issues an instruction with a destination register
- i_claim_addr  in  ADDR_W  destination being claimed
- o_busy  out  32  bit i set: register i has an outstanding write
- o_rf_we  out  1  register-file write enable
- o_rf_wa  out  ADDR_W  register-file write address
- o_rf_wd  out  DATA_W  register-file write data

## Operation
- Accept: requester X accepted when i_x_valid && o_x_ready. At most one accept per cycle.
- Grant (combinational from valid and pointer):
  - only one valid → that one granted.
  - both valid → the requester not granted most recently.
  - none valid → both ready low.
  - both ready low while rstn low.
- Round-robin pointer (`last`): records last accepted requester; updated on every accept; reset value B, so A wins the first contention.
- Write stage: on accept, register o_rf_wa/o_rf_wd ← accepted addr/data; o_rf_we ← 1 unless addr == 0. Writes to r0 are accepted (ready high) but produce o_rf_we = 0. No accept → o_rf_we ← 0; o_rf_wa/o_rf_wd hold.
- Scoreboard (32 bits, bit 0 always 0):
  - Set: i_claim_valid && i_claim_addr != 0 → busy[i_claim_addr] ← 1.
  - Clear: o_rf_we high → busy[o_rf_wa] ← 0 at that edge (same edge the register file commits).
  - Same register set and cleared in one cycle → set wins (newer producer).
  - Claim of an already-busy register: stays 1; no counting. A single outstanding producer per register is a decode-side guarantee.
- Reset: o_rf_we = 0, o_rf_wa = 0, o_rf_wd = 0, o_busy = 0, last = B. Reset mid-operation drops any registered write: o_rf_we = 0 the cycle after the rstn-low edge.

## Timing
- Accept at edge N → o_rf_we/wa/wd valid during cycle N+1 → register file writes at edge N+1 → busy bit clear from N+1.
- Ready: same-cycle combinational on valid; no valid-to-ready dependency on data.
- Throughput: one write per cycle; the contended requester waits exactly one cycle if the other stops requesting; under continuous contention, grants alternate A,B,A,B.
- Requesters hold valid/addr/data stable until accepted.
- Claim at edge N → o_busy bit visible from N (registered, after edge N).

## Configuration
- REGFILE_WB_SCOREBOARD_EN:
  - Defined: scoreboard as above.
  - Undefined: no scoreboard state; o_busy tied to 0; i_claim_* ignored.
  - Arbitration and write stage identical in both builds.

## Test plan
- Reset: hold rstn low 2 cycles with both valid → ready low, o_rf_we = 0, o_busy = 0.
- Single A write addr 5 data 0xDEADBEEF at edge N → o_a_ready = 1 in cycle N; o_rf_we = 1, wa = 5, wd = 0xDEADBEEF in cycle N+1; o_rf_we = 0 in cycle N+2.
- Both valid continuously for 4 cycles (A addr 1, B addr 2) → grant sequence A,B,A,B; o_rf_wa sequence 1,2,1,2.
- Write to r0 from B with data 0x1234 → o_b_ready = 1; o_rf_we stays 0 next cycle.
- Scoreboard (macro defined): claim r7 at edge N → o_busy[7] = 1; A writes r7 accepted at edge M → busy[7] clears at M+1. Claim r7 and commit r7 in the same cycle → busy[7] stays 1.
- Macro undefined: claim r7 → o_busy = 0 throughout; writes unaffected.
